// File: rtl/excp_commit_ctrl_pkg.sv
// Shared definitions for the exception commit sequencer: exception codes,
// FSM state encoding, the zero constant and the BadVAddr qualifier.
package excp_commit_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [31:0] ZERO32 = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_REDIRECT = 3'd4
    } state_t;

    // Address-related exceptions are the only ones that report a faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_MOD)  || (code == EXC_TLBL) || (code == EXC_TLBS) ||
               (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/excp_commit_ctrl_if.sv
// Bundle between the exception-detect/pipe side (master) and the commit
// sequencer (slave): exception capture, bus drain, CP0 commit and redirect.
interface excp_commit_ctrl_if;
    import excp_commit_ctrl_pkg::*;

    logic        excp_valid_i;
    logic [4:0]  excp_code_i;
    logic [31:0] excp_pc_i;
    logic [31:0] inst_addr_i;
    logic        in_delay_slot_i;
    logic [31:0] bad_vaddr_i;
    logic        mem_busy_i;
    logic        redirect_ready_i;

    logic        stall_o;
    logic        flush_o;
    logic        cp0_we_o;
    logic [31:0] epc_o;
    logic [4:0]  exc_code_o;
    logic        bd_o;
    logic        badvaddr_we_o;
    logic [31:0] badvaddr_o;
    logic        exl_set_o;
    logic        exl_clr_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    modport master (
        output excp_valid_i, excp_code_i, excp_pc_i, inst_addr_i, in_delay_slot_i,
               bad_vaddr_i, mem_busy_i, redirect_ready_i,
        input  stall_o, flush_o, cp0_we_o, epc_o, exc_code_o, bd_o, badvaddr_we_o,
               badvaddr_o, exl_set_o, exl_clr_o, redirect_valid_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  excp_valid_i, excp_code_i, excp_pc_i, inst_addr_i, in_delay_slot_i,
               bad_vaddr_i, mem_busy_i, redirect_ready_i,
        output stall_o, flush_o, cp0_we_o, epc_o, exc_code_o, bd_o, badvaddr_we_o,
               badvaddr_o, exl_set_o, exl_clr_o, redirect_valid_o, redirect_pc_o, busy_o
    );

endinterface

// File: rtl/excp_commit_ctrl_cp0_fmt.sv
// Combinational formatter: turns the latched exception fields into the
// CP0 write values and per-register enables.
module excp_cp0_fmt
    import excp_commit_ctrl_pkg::*;
(
    input  logic [4:0]  code,
    input  logic [31:0] inst_addr,
    input  logic        in_delay_slot,
    output logic [31:0] epc,
    output logic        bd,
    output logic        badvaddr_we,
    output logic        exl_set,
    output logic        exl_clr
);
    logic is_eret;

    assign is_eret     = (code == EXC_ERET);
    // A delay-slot fault restarts at the branch, one word earlier (wraps mod 2^32).
    assign epc         = in_delay_slot ? (inst_addr - 32'd4) : inst_addr;
    assign bd          = in_delay_slot;
    assign badvaddr_we = is_addr_exc(code);
    assign exl_set     = !is_eret;
    assign exl_clr     = is_eret;

endmodule

// File: rtl/excp_commit_ctrl.sv
// Exception commit sequencer: capture -> drain data bus -> CP0 commit ->
// flush -> redirect fetch.
// Optional feature macro: EXCP_DRAIN_TIMEOUT_EN bounds the drain wait and
// adds the sticky drain_timeout_o output.
//
// state    | meaning
// IDLE     | waiting for a taken exception
// DRAIN    | exception latched, waiting for the data bus to go idle
// COMMIT   | single cycle of CP0 write strobes
// FLUSH    | flush_o held for FLUSH_CYCLES cycles
// REDIRECT | redirect_valid_o held until fetch accepts
module excp_commit_ctrl
    import excp_commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
`ifdef EXCP_DRAIN_TIMEOUT_EN
    ,
    parameter int DRAIN_TIMEOUT = 255
`endif
) (
    input  logic clk,
    input  logic rst,
`ifdef EXCP_DRAIN_TIMEOUT_EN
    output logic drain_timeout_o,
`endif
    excp_commit_ctrl_if.slave bus
);
    localparam int            FW         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(1);

    state_t        state;
    logic [FW-1:0] flush_cnt;

    logic [4:0]    lat_code;
    logic [31:0]   lat_vec;
    logic [31:0]   lat_inst;
    logic [31:0]   lat_bad;
    logic          lat_bd;

    logic [31:0]   fmt_epc;
    logic          fmt_bd;
    logic          fmt_bwe;
    logic          fmt_set;
    logic          fmt_clr;

    logic          flush_q;
    logic          cp0_we_q;
    logic          bwe_q;
    logic          set_q;
    logic          clr_q;
    logic          rv_q;
    logic          bd_q;
    logic [4:0]    code_q;
    logic [31:0]   epc_q;
    logic [31:0]   bad_q;
    logic [31:0]   rpc_q;

    logic          drain_go;

`ifdef EXCP_DRAIN_TIMEOUT_EN
    localparam int            DW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_TIMEOUT);

    logic [DW-1:0] drain_cnt;
    logic          drain_expired;
    logic          timeout_q;

    // Down-counter is loaded on DRAIN entry; terminal count is its last DRAIN cycle.
    assign drain_expired   = (drain_cnt == DW'(1));
    assign drain_go        = !bus.mem_busy_i || drain_expired;
    assign drain_timeout_o = timeout_q;
`else
    assign drain_go = !bus.mem_busy_i;
`endif

    excp_cp0_fmt u_fmt (
        .code          (lat_code),
        .inst_addr     (lat_inst),
        .in_delay_slot (lat_bd),
        .epc           (fmt_epc),
        .bd            (fmt_bd),
        .badvaddr_we   (fmt_bwe),
        .exl_set       (fmt_set),
        .exl_clr       (fmt_clr)
    );

    // Sequencer state, latched exception fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            lat_code  <= 5'd0;
            lat_vec   <= ZERO32;
            lat_inst  <= ZERO32;
            lat_bad   <= ZERO32;
            lat_bd    <= 1'b0;
            flush_q   <= 1'b0;
            cp0_we_q  <= 1'b0;
            bwe_q     <= 1'b0;
            set_q     <= 1'b0;
            clr_q     <= 1'b0;
            rv_q      <= 1'b0;
            bd_q      <= 1'b0;
            code_q    <= 5'd0;
            epc_q     <= ZERO32;
            bad_q     <= ZERO32;
            rpc_q     <= ZERO32;
`ifdef EXCP_DRAIN_TIMEOUT_EN
            drain_cnt <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            cp0_we_q <= 1'b0;
            bwe_q    <= 1'b0;
            set_q    <= 1'b0;
            clr_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.excp_valid_i) begin
                        lat_code <= bus.excp_code_i;
                        lat_vec  <= bus.excp_pc_i;
                        lat_inst <= bus.inst_addr_i;
                        lat_bad  <= bus.bad_vaddr_i;
                        lat_bd   <= bus.in_delay_slot_i;
                        state    <= ST_DRAIN;
`ifdef EXCP_DRAIN_TIMEOUT_EN
                        drain_cnt <= DRAIN_LOAD;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (drain_go) begin
                        state    <= ST_COMMIT;
                        cp0_we_q <= 1'b1;
                        bwe_q    <= fmt_bwe;
                        set_q    <= fmt_set;
                        clr_q    <= fmt_clr;
                        code_q   <= lat_code;
                        bd_q     <= fmt_bd;
                        bad_q    <= lat_bad;
                        // eret reads EPC back as its target, so EPC must survive it
                        if (!fmt_clr) begin
                            epc_q <= fmt_epc;
                        end
`ifdef EXCP_DRAIN_TIMEOUT_EN
                        if (bus.mem_busy_i) begin
                            timeout_q <= 1'b1;
                        end
`endif
                    end
`ifdef EXCP_DRAIN_TIMEOUT_EN
                    else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
`endif
                end
                ST_COMMIT: begin
                    state     <= ST_FLUSH;
                    flush_q   <= 1'b1;
                    flush_cnt <= FLUSH_LOAD;
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state   <= ST_REDIRECT;
                        flush_q <= 1'b0;
                        rv_q    <= 1'b1;
                        rpc_q   <= lat_vec;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                ST_REDIRECT: begin
                    if (rv_q && bus.redirect_ready_i) begin
                        rv_q  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o           = (state != ST_IDLE);
    assign bus.stall_o          = bus.excp_valid_i | (state != ST_IDLE);
    assign bus.flush_o          = flush_q;
    assign bus.cp0_we_o         = cp0_we_q;
    assign bus.epc_o            = epc_q;
    assign bus.exc_code_o       = code_q;
    assign bus.bd_o             = bd_q;
    assign bus.badvaddr_we_o    = bwe_q;
    assign bus.badvaddr_o       = bad_q;
    assign bus.exl_set_o        = set_q;
    assign bus.exl_clr_o        = clr_q;
    assign bus.redirect_valid_o = rv_q;
    assign bus.redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Self-checking bench for excp_commit_ctrl. Stimulus is a pre-built per-cycle
// table (directed opening section, then random traffic); expected outputs are
// derived per exception as a timeline (accept, commit, flush window, redirect
// hand-off, truncation by reset) and compared every cycle.
module tb_excp_commit_ctrl;
    import excp_commit_ctrl_pkg::*;

    localparam int N  = 3000;
    localparam int FC = 2;
    localparam int DT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    excp_commit_ctrl_if bus();

`ifdef EXCP_DRAIN_TIMEOUT_EN
    logic drain_timeout;
    excp_commit_ctrl #(.FLUSH_CYCLES(FC), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst), .drain_timeout_o(drain_timeout), .bus(bus));
`else
    excp_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    // stimulus table
    bit          s_rst [N];
    bit          s_exc [N];
    bit          s_busy[N];
    bit          s_rdy [N];
    bit          s_bd  [N];
    logic [4:0]  s_code[N];
    logic [31:0] s_vec [N];
    logic [31:0] s_inst[N];
    logic [31:0] s_bad [N];

    // expected per-cycle outputs
    bit          e_busy[N], e_cp0[N], e_flush[N], e_rv[N];
    bit          e_bwe[N], e_set[N], e_clr[N], e_dto[N];
    logic [31:0] e_epc[N], e_bad[N], e_rpc[N];
    logic [4:0]  e_code[N];
    bit          e_bd[N];

    // register update events (forward-filled into the expected arrays)
    bit          u_cause[N], u_epc[N], u_rpc[N], u_dto[N];
    logic [31:0] v_epc[N], v_bad[N], v_rpc[N];
    logic [4:0]  v_code[N];
    bit          v_bd[N];

    logic [4:0]  codes[11];
    int n_tests = 0;
    int n_fail  = 0;
    int cur_cyc = 0;
    bit running = 1'b0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic build_model();
        int t, a, cut, c, r0, r1, fin;
        bit to;
        logic [4:0] cc;
        logic [31:0] ep, bv, rp;
        bit bdv, dv;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = 0; e_cp0[i] = 0; e_flush[i] = 0; e_rv[i] = 0;
            e_bwe[i] = 0; e_set[i] = 0; e_clr[i] = 0;
            u_cause[i] = 0; u_epc[i] = 0; u_rpc[i] = 0; u_dto[i] = 0;
        end
        t = 0;
        while (t < N) begin
            if (s_exc[t] && !s_rst[t]) begin
                a = t;
                cut = N;
                for (int j = N - 1; j > a; j--) if (s_rst[j]) cut = j;
                // commit lands the cycle after the first idle-bus drain cycle
                c = N;
                to = 0;
                for (int j = a + 1; j < N && c == N; j++) begin
                    if (!s_busy[j]) c = j + 1;
`ifdef EXCP_DRAIN_TIMEOUT_EN
                    else if (j == a + DT) begin c = j + 1; to = 1; end
`endif
                end
                r0 = c + FC + 1;
                r1 = N;
                for (int j = N - 1; j >= r0; j--) if (s_rdy[j]) r1 = j;
                fin = (r1 < cut) ? r1 : cut;
                for (int j = a + 1; j <= fin && j < N; j++) begin
                    e_busy[j] = 1;
                    if (j == c) begin
                        e_cp0[j] = 1;
                        e_clr[j] = (s_code[a] == EXC_ERET);
                        e_set[j] = (s_code[a] != EXC_ERET);
                        e_bwe[j] = (s_code[a] inside {EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES});
                        u_cause[j] = 1;
                        v_code[j] = s_code[a];
                        v_bd[j]   = s_bd[a];
                        v_bad[j]  = s_bad[a];
                        if (s_code[a] != EXC_ERET) begin
                            u_epc[j] = 1;
                            v_epc[j] = s_bd[a] ? s_inst[a] - 32'd4 : s_inst[a];
                        end
                        if (to) u_dto[j] = 1;
                    end
                    if (j > c && j <= c + FC) e_flush[j] = 1;
                    if (j >= r0) e_rv[j] = 1;
                    if (j == r0) begin u_rpc[j] = 1; v_rpc[j] = s_vec[a]; end
                end
                t = fin + 1;
            end else begin
                t++;
            end
        end
        cc = 0; ep = 0; bv = 0; rp = 0; bdv = 0; dv = 0;
        for (int i = 0; i < N; i++) begin
            if (i > 0 && s_rst[i-1]) begin cc = 0; ep = 0; bv = 0; rp = 0; bdv = 0; dv = 0; end
            if (u_cause[i]) begin cc = v_code[i]; bv = v_bad[i]; bdv = v_bd[i]; end
            if (u_epc[i]) ep = v_epc[i];
            if (u_rpc[i]) rp = v_rpc[i];
            if (u_dto[i]) dv = 1;
            e_code[i] = cc; e_epc[i] = ep; e_bad[i] = bv; e_rpc[i] = rp; e_bd[i] = bdv; e_dto[i] = dv;
        end
    endtask

    task automatic exc_at(input int t, input logic [4:0] code, input logic [31:0] vec,
                          input logic [31:0] inst, input bit bd, input logic [31:0] bad);
        s_exc[t] = 1; s_code[t] = code; s_vec[t] = vec; s_inst[t] = inst; s_bd[t] = bd; s_bad[t] = bad;
    endtask

    task automatic gen_stim();
        codes = '{EXC_INT, EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES,
                  EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET};
        for (int t = 0; t < N; t++) begin
            s_code[t] = codes[$urandom_range(0, 10)];
            s_vec[t]  = $urandom;
            s_inst[t] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            s_bd[t]   = 1'($urandom_range(0, 1));
            s_bad[t]  = $urandom;
            if (t < 75 || t >= N - 200) begin
                s_rst[t] = (t < 3); s_exc[t] = 0; s_busy[t] = 0; s_rdy[t] = 1;
            end else begin
                s_rst[t]  = ($urandom_range(0, 199) == 0);
                s_exc[t]  = ($urandom_range(0, 3) == 0);
                s_busy[t] = 1'($urandom_range(0, 1));
                s_rdy[t]  = ($urandom_range(0, 2) != 0);
            end
        end
        exc_at(5,  EXC_SYS,  32'h8000_0180, 32'h8000_1000, 0, 32'h1234_5678);
        exc_at(14, EXC_ADES, 32'h8000_0180, 32'h8000_2004, 1, 32'h0000_0013);
        exc_at(22, EXC_OV,   32'h8000_0180, 32'h8000_3000, 0, 32'h0);
        for (int t = 23; t <= 32; t++) s_busy[t] = 1;
        exc_at(42, EXC_ERET, 32'hBFC0_0380, 32'h8000_4444, 0, 32'h0);
        s_rdy[47] = 0; s_rdy[48] = 0; s_rdy[49] = 0;
        exc_at(55, EXC_SYS,  32'h8000_0200, 32'h8000_5000, 0, 32'h0);
        exc_at(58, EXC_BP,   32'h8000_0300, 32'h8000_6000, 0, 32'h0);
        exc_at(64, EXC_TLBL, 32'h8000_0400, 32'h8000_7000, 0, 32'hDEAD_0000);
        for (int t = 65; t <= 70; t++) s_busy[t] = 1;
        s_rst[66] = 1;
    endtask

    task automatic pin_model();
        int n;
        chk("pin_reset_busy", 1, 32'(e_busy[1]), 32'd0);
        chk("pin_t1_cp0", 7, 32'(e_cp0[7]), 32'd1);
        chk("pin_t1_epc", 7, e_epc[7], 32'h8000_1000);
        chk("pin_t1_code", 7, 32'(e_code[7]), 32'h08);
        chk("pin_t1_bwe", 7, 32'(e_bwe[7]), 32'd0);
        chk("pin_t1_set", 7, 32'(e_set[7]), 32'd1);
        chk("pin_t1_flush", 8, 32'({e_flush[7], e_flush[8], e_flush[9], e_flush[10]}), 32'b0110);
        chk("pin_t1_rv", 10, 32'(e_rv[10]), 32'd1);
        chk("pin_t1_rpc", 10, e_rpc[10], 32'h8000_0180);
        chk("pin_t1_idle", 11, 32'(e_busy[11]), 32'd0);
        chk("pin_t2_epc", 16, e_epc[16], 32'h8000_2000);
        chk("pin_t2_bd", 16, 32'(e_bd[16]), 32'd1);
        chk("pin_t2_bwe", 16, 32'(e_bwe[16]), 32'd1);
        chk("pin_t2_bad", 16, e_bad[16], 32'h0000_0013);
`ifdef EXCP_DRAIN_TIMEOUT_EN
        chk("pin_t6_cp0", 27, 32'({e_cp0[26], e_cp0[27]}), 32'b01);
        chk("pin_t6_dto", 60, 32'(e_dto[60]), 32'd1);
        chk("pin_t6_dto_rst", 67, 32'(e_dto[67]), 32'd0);
`else
        chk("pin_t3_cp0", 34, 32'({e_cp0[33], e_cp0[34]}), 32'b01);
`endif
        chk("pin_t4_clr", 44, 32'({e_clr[44], e_set[44]}), 32'b10);
        chk("pin_t4_epc", 44, e_epc[44], 32'h8000_3000);
        chk("pin_t4_rv", 47, 32'({e_rv[47], e_rv[48], e_rv[49], e_rv[50], e_rv[51]}), 32'b11110);
        chk("pin_t4_rpc", 50, e_rpc[50], 32'hBFC0_0380);
        n = 0;
        for (int t = 55; t <= 61; t++) n += int'(e_cp0[t]);
        chk("pin_t5_one_commit", 55, 32'(n), 32'd1);
        n = 0;
        for (int t = 64; t <= 74; t++) n += int'(e_cp0[t]);
        chk("pin_rst_no_commit", 64, 32'(n), 32'd0);
        chk("pin_rst_idle", 67, 32'({e_busy[67], e_rv[67]}), 32'd0);
        chk("pin_rst_epc", 67, e_epc[67], 32'h0);
    endtask

    // Single compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (running && cur_cyc >= 1) begin
            chk("busy",      cur_cyc, 32'(bus.busy_o),           32'(e_busy[cur_cyc]));
            chk("stall",     cur_cyc, 32'(bus.stall_o),          32'(s_exc[cur_cyc] | e_busy[cur_cyc]));
            chk("cp0_we",    cur_cyc, 32'(bus.cp0_we_o),         32'(e_cp0[cur_cyc]));
            chk("flush",     cur_cyc, 32'(bus.flush_o),          32'(e_flush[cur_cyc]));
            chk("rvalid",    cur_cyc, 32'(bus.redirect_valid_o), 32'(e_rv[cur_cyc]));
            chk("rpc",       cur_cyc, bus.redirect_pc_o,         e_rpc[cur_cyc]);
            chk("epc",       cur_cyc, bus.epc_o,                 e_epc[cur_cyc]);
            chk("exc_code",  cur_cyc, 32'(bus.exc_code_o),       32'(e_code[cur_cyc]));
            chk("bd",        cur_cyc, 32'(bus.bd_o),             32'(e_bd[cur_cyc]));
            chk("bvaddr_we", cur_cyc, 32'(bus.badvaddr_we_o),    32'(e_bwe[cur_cyc]));
            chk("bvaddr",    cur_cyc, bus.badvaddr_o,            e_bad[cur_cyc]);
            chk("exl_set",   cur_cyc, 32'(bus.exl_set_o),        32'(e_set[cur_cyc]));
            chk("exl_clr",   cur_cyc, 32'(bus.exl_clr_o),        32'(e_clr[cur_cyc]));
`ifdef EXCP_DRAIN_TIMEOUT_EN
            chk("drain_to",  cur_cyc, 32'(drain_timeout),        32'(e_dto[cur_cyc]));
`endif
        end
    end

    initial begin
        rst = 1'b1;
        bus.excp_valid_i = 0; bus.excp_code_i = 0; bus.excp_pc_i = 0; bus.inst_addr_i = 0;
        bus.in_delay_slot_i = 0; bus.bad_vaddr_i = 0; bus.mem_busy_i = 0; bus.redirect_ready_i = 0;
        gen_stim();
        build_model();
        pin_model();
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            #1;
            rst                  = s_rst[t];
            bus.excp_valid_i     = s_exc[t];
            bus.excp_code_i      = s_code[t];
            bus.excp_pc_i        = s_vec[t];
            bus.inst_addr_i      = s_inst[t];
            bus.in_delay_slot_i  = s_bd[t];
            bus.bad_vaddr_i      = s_bad[t];
            bus.mem_busy_i       = s_busy[t];
            bus.redirect_ready_i = s_rdy[t];
            cur_cyc              = t;
            running              = 1'b1;
        end
        @(posedge clk);
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
